// File: rtl/mem_copy_engine.sv
// Byte-wide memory copy/fill engine: one read and one write per copied byte, one write per filled byte.
// Fill support is compiled in only when MEM_COPY_FILL_EN is defined; otherwise every transfer is a copy.

package definitions;
    parameter int D_WIDTH = 8;
endpackage

module mem_copy_engine
    import definitions::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         src_addr,
    input  logic [7:0]         dst_addr,
    input  logic [7:0]         length,
    input  logic               fill_mode,
    input  logic [D_WIDTH-1:0] fill_value,
    output logic [7:0]         mem_addr,
    output logic               mem_write,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_src;
    logic [7:0]         r_dst;
    logic [7:0]         r_len;
    logic [7:0]         r_i;
    logic [D_WIDTH-1:0] r_data;

    logic               w_accept;
    logic               w_last;
    logic               w_start_fill;
    logic               w_fill;
    logic [D_WIDTH-1:0] w_fill_val;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_i == (r_len - 8'd1));

`ifdef MEM_COPY_FILL_EN
    logic               r_fill;
    logic [D_WIDTH-1:0] r_fill_val;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fill     <= fill_mode;
            r_fill_val <= fill_value;
        end
    end

    assign w_start_fill = fill_mode;
    assign w_fill       = r_fill;
    assign w_fill_val   = r_fill_val;
`else
    // Fill ports stay on the boundary so both builds share one pinout.
    logic w_unused_fill;
    assign w_unused_fill = ^{fill_mode, fill_value};

    assign w_start_fill = 1'b0;
    assign w_fill       = 1'b0;
    assign w_fill_val   = '0;
`endif

    // Transfer operands are captured once per request and held until the next one.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_len <= length;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_i     <= 8'd0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i <= 8'd0;
                    end
                end
                READ: begin
                    r_data <= mem_rdata;
                end
                WRITE: begin
                    if (!w_last) begin
                        r_i <= r_i + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length == 8'd0) begin
                        w_state_nxt = DONE;
                    end else if (w_start_fill) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                w_state_nxt = WRITE;
            end
            WRITE: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else if (w_fill) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address sums are 8 bits wide so they wrap from 0xFF to 0x00.
    always_comb begin
        mem_addr  = 8'd0;
        mem_write = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            READ: begin
                mem_addr = r_src + r_i;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_addr  = r_dst + r_i;
                mem_write = 1'b1;
                mem_wdata = w_fill ? w_fill_val : r_data;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural byte memory (async read, clocked write).
// Expectations follow the MEM_COPY_FILL_EN setting of the build.

module tb_mem_copy_engine;
    import definitions::*;

    logic               clk;
    logic               reset;
    logic               start;
    logic [7:0]         src_addr;
    logic [7:0]         dst_addr;
    logic [7:0]         length;
    logic               fill_mode;
    logic [D_WIDTH-1:0] fill_value;
    logic [7:0]         mem_addr;
    logic               mem_write;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;
    logic               busy;
    logic               done;

    logic [D_WIDTH-1:0] mem [0:255];
    logic               ld_en;
    logic [7:0]         ld_addr;
    logic [D_WIDTH-1:0] ld_data;

    logic               lg_wr   [0:63];
    logic [7:0]         lg_addr [0:63];
    logic [D_WIDTH-1:0] lg_data [0:63];
    logic               lg_busy [0:63];
    logic               lg_done [0:63];
    int                 done_cyc;
    int                 done_cnt;
    int                 n_wr;
    int                 busy_cnt;

    int n_tests;
    int n_fail;

    mem_copy_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [D_WIDTH-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Issues start at edge 0 and logs cycles 1..ncyc (sampled 1 time unit after each edge).
    task automatic xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                        input logic fm, input logic [D_WIDTH-1:0] fv,
                        input int restart_cyc, input int reset_cyc, input int ncyc);
        src_addr   = s;
        dst_addr   = d;
        length     = n;
        fill_mode  = fm;
        fill_value = fv;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        src_addr   = 8'hFF;
        dst_addr   = 8'hFF;
        length     = 8'hFF;
        fill_mode  = ~fm;
        fill_value = 8'hC3;
        done_cyc = 0;
        done_cnt = 0;
        n_wr     = 0;
        busy_cnt = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == restart_cyc) begin
                src_addr = 8'h00;
                dst_addr = 8'hC0;
                length   = 8'd1;
                start    = 1'b1;
            end
            if (k == reset_cyc) reset = 1'b1;
            lg_wr[k]   = mem_write;
            lg_addr[k] = mem_addr;
            lg_data[k] = mem_wdata;
            lg_busy[k] = busy;
            lg_done[k] = done;
            if (mem_write) n_wr++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            reset = 1'b0;
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        src_addr   = 8'h00;
        dst_addr   = 8'h00;
        length     = 8'h00;
        fill_mode  = 1'b0;
        fill_value = 8'h00;
        ld_en      = 1'b0;
        ld_addr    = 8'h00;
        ld_data    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        reset = 1'b0;

        // Plain copy of four bytes
        load(8'h10, 8'h11);
        load(8'h11, 8'h22);
        load(8'h12, 8'h33);
        load(8'h13, 8'h44);
        xfer(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 0, 0, 12);
        chk("copy_done_cyc", done_cyc, 9);
        chk("copy_done_cnt", done_cnt, 1);
        chk("copy_writes", n_wr, 4);
        chk("copy_wr_addr2", lg_addr[2], 8'h80);
        chk("copy_wr_addr8", lg_addr[8], 8'h83);
        chk("copy_rd_addr3", lg_addr[3], 8'h11);
        chk("copy_m80", mem[8'h80], 8'h11);
        chk("copy_m81", mem[8'h81], 8'h22);
        chk("copy_m82", mem[8'h82], 8'h33);
        chk("copy_m83", mem[8'h83], 8'h44);
        chk("copy_busy_cyc10", lg_busy[10], 1'b0);

        // Wrapping, forward-overlapping copy
        load(8'hFE, 8'hA1);
        load(8'hFF, 8'hB2);
        load(8'h00, 8'hC3);
        xfer(8'hFE, 8'hFF, 8'd3, 1'b0, 8'h00, 0, 0, 10);
        chk("wrap_done_cyc", done_cyc, 7);
        chk("wrap_writes", n_wr, 3);
        chk("wrap_addr2", lg_addr[2], 8'hFF);
        chk("wrap_addr4", lg_addr[4], 8'h00);
        chk("wrap_addr6", lg_addr[6], 8'h01);
        chk("wrap_data2", lg_data[2], 8'hA1);
        chk("wrap_data4", lg_data[4], 8'hA1);
        chk("wrap_data6", lg_data[6], 8'hA1);
        chk("wrap_m01", mem[8'h01], 8'hA1);

        // Zero-length request
        xfer(8'h10, 8'h50, 8'd0, 1'b0, 8'h00, 0, 0, 4);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_writes", n_wr, 0);
        chk("zero_busy", busy_cnt, 0);

        // Fill request (a copy when fill is compiled out)
        load(8'h20, 8'h01);
        load(8'h21, 8'h02);
        load(8'h22, 8'h03);
        load(8'h23, 8'h04);
        load(8'h24, 8'h05);
        xfer(8'h20, 8'h40, 8'd5, 1'b1, 8'h5A, 0, 0, 14);
`ifdef MEM_COPY_FILL_EN
        chk("fill_done_cyc", done_cyc, 6);
        chk("fill_writes", n_wr, 5);
        chk("fill_busy", busy_cnt, 5);
        chk("fill_m40", mem[8'h40], 8'h5A);
        chk("fill_m42", mem[8'h42], 8'h5A);
        chk("fill_m44", mem[8'h44], 8'h5A);
`else
        chk("fill_done_cyc", done_cyc, 11);
        chk("fill_writes", n_wr, 5);
        chk("fill_busy", busy_cnt, 10);
        chk("fill_m40", mem[8'h40], 8'h01);
        chk("fill_m42", mem[8'h42], 8'h03);
        chk("fill_m44", mem[8'h44], 8'h05);
`endif

        // Reset in cycle 6 of an eight-byte copy
        for (int j = 0; j < 8; j++) begin
            load(8'h30 + 8'(j), 8'h31 + 8'(j));
            load(8'hA0 + 8'(j), 8'hEE);
        end
        xfer(8'h30, 8'hA0, 8'd8, 1'b0, 8'h00, 0, 6, 20);
        chk("rst_mid_writes", n_wr, 3);
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_busy7", lg_busy[7], 1'b0);
        chk("rst_mid_wr7", lg_wr[7], 1'b0);
        chk("rst_mid_addr7", lg_addr[7], 8'h00);
        chk("rst_mid_mA2", mem[8'hA2], 8'h33);
        chk("rst_mid_mA3", mem[8'hA3], 8'hEE);

        // Second start while busy is ignored
        load(8'hC0, 8'h77);
        xfer(8'h10, 8'h90, 8'd4, 1'b0, 8'h00, 3, 0, 14);
        chk("rest_done_cyc", done_cyc, 9);
        chk("rest_done_cnt", done_cnt, 1);
        chk("rest_writes", n_wr, 4);
        chk("rest_addr8", lg_addr[8], 8'h93);
        chk("rest_m90", mem[8'h90], 8'h11);
        chk("rest_m93", mem[8'h93], 8'h44);
        chk("rest_mC0", mem[8'hC0], 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL import definitions::* and use D_WIDTH for all data widths; parameters: none.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port src_addr, input, 8 bits: first source byte address.
REQ-006 SHALL have port dst_addr, input, 8 bits: first destination byte address.
REQ-007 SHALL have port length, input, 8 bits: byte count; 0 means no transfer.
REQ-008 SHALL have port fill_mode, input, 1 bit: selects fill instead of copy (see REQ-027).
REQ-009 SHALL have port fill_value, input, D_WIDTH bits: the fill byte.
REQ-010 SHALL have port mem_addr, output, 8 bits: memory address.
REQ-011 SHALL have port mem_write, output, 1 bit: memory write strobe.
REQ-012 SHALL have port mem_wdata, output, D_WIDTH bits: memory write data.
REQ-013 SHALL have port mem_rdata, input, D_WIDTH bits: asynchronous memory read data for mem_addr in the same cycle.
REQ-014 SHALL have port busy, output, 1 bit: high in READ and WRITE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-017 At a clock edge in IDLE with start=1, SHALL latch src_addr, dst_addr, length, fill_mode and fill_value, and clear the index i to 0.
REQ-018 From IDLE on start, SHALL go to DONE if length=0, else to WRITE if fill mode is active, else to READ.
REQ-019 In READ, SHALL drive mem_addr=src+i, mem_write=0, and capture mem_rdata into a data register at the edge; next state WRITE.
REQ-020 In WRITE, SHALL drive mem_addr=dst+i, mem_write=1, and mem_wdata = the data register (copy) or the latched fill_value (fill).
REQ-021 At the WRITE edge, SHALL go to DONE if i=length-1, else increment i and return to READ (copy) or stay in WRITE (fill).
REQ-022 In DONE, SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-023 In IDLE and DONE, SHALL drive mem_write=0, mem_addr=0 and mem_wdata=0.
REQ-024 Address arithmetic SHALL be modulo 256 (src+i and dst+i wrap from 0xFF to 0x00); i SHALL be 8 bits, and length=255 SHALL transfer 255 bytes.
REQ-025 SHALL ignore start while not in IDLE, and ignore input changes after the latching edge.
REQ-026 Copies SHALL proceed in ascending byte order, one read then one write per byte; overlapping regions are defined by that order, with no hazard correction.
REQ-027 Timing with start sampled at edge 0 SHALL be: copy of N bytes asserts done in cycle 2N+1; fill asserts done in cycle N+1; length=0 asserts done in cycle 1.

Reset
REQ-028 With reset=1 at a clock edge, SHALL enter IDLE, clear i and the data register, and give busy=0, done=0, mem_write=0, mem_addr=0 and mem_wdata=0 from the next cycle, including mid-transfer.
REQ-029 A reset mid-transfer SHALL abandon the transfer, assert no done, and leave bytes already written unchanged.

Configuration
REQ-030 Macro MEM_COPY_FILL_EN defined: fill_mode and fill_value SHALL behave as in REQ-018, REQ-020 and REQ-021.
REQ-031 MEM_COPY_FILL_EN undefined: the fill_mode and fill_value ports SHALL remain but be ignored, and every transfer SHALL be a copy.

Verification
REQ-032 Copy: memory[0x10..0x13]=11,22,33,44, src=0x10, dst=0x80, len=4 -> memory[0x80..0x83]=11,22,33,44; done in cycle 9; exactly 4 mem_write cycles.
REQ-033 Wrap: src=0xFE, dst=0xFF, len=3, memory[0xFE,0xFF,0x00]=A1,B2,C3 -> writes to 0xFF, 0x00, 0x01 with A1, A1, A1 (forward-overlap propagation).
REQ-034 Zero length: len=0 -> done in cycle 1; mem_write never asserted; busy never asserted.
REQ-035 Fill (MEM_COPY_FILL_EN defined): dst=0x40, len=5, fill_value=0x5A -> memory[0x40..0x44]=0x5A; done in cycle 6; without the macro the same stimulus performs a copy.
REQ-036 Reset mid-transfer: copy with len=8 and reset asserted in cycle 6 -> exactly 3 bytes written (WRITE states in cycles 2, 4, 6); outputs zero from the next cycle; no done.
REQ-037 Start while busy: a second start pulse in cycle 3 of a len=4 copy is ignored -> single done in cycle 9; latched addresses unchanged.
